// File: rtl/lut_ctrl.sv
// Command sequencer for the 8-bit LUT/register file: expands write/read commands into
// save_data / write_en / show_reg strobes on the shared d_in bus and returns read data.
module lut_ctrl #(
    parameter int DW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_wr,
    input  logic [DW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_data,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          busy,
    output logic [DW-1:0] lut_d_in,
    output logic          lut_save_data,
    output logic          lut_write_en,
    output logic          lut_show_reg,
    input  logic [DW-1:0] lut_d_out
);

    typedef enum logic [2:0] {
        IDLE,
        W_SAVE,
        W_COMMIT,
        R_SHOW,
        R_WAIT,
        R_RSP
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(RD_LAT - 1);

    state_t        state_reg, state_next;
    logic [DW-1:0] addr_reg, addr_next;
    logic [3:0]    cnt_reg, cnt_next;
    logic [DW-1:0] d_in_reg, d_in_next;
    logic [DW-1:0] rsp_data_reg, rsp_data_next;
    logic          cmd_ready_reg, cmd_ready_next;
    logic          busy_reg, busy_next;
    logic          save_reg, save_next;
    logic          write_reg, write_next;
    logic          show_reg, show_next;
    logic          rsp_valid_reg, rsp_valid_next;

    always_comb begin
        state_next    = state_reg;
        addr_next     = addr_reg;
        cnt_next      = cnt_reg;
        d_in_next     = d_in_reg;
        rsp_data_next = rsp_data_reg;

        case (state_reg)
            IDLE: begin
                if (cmd_valid && cmd_ready_reg) begin
                    addr_next = cmd_addr;
                    if (cmd_wr) begin
                        state_next = W_SAVE;
                        d_in_next  = cmd_data;
                    end else begin
                        state_next = R_SHOW;
                        d_in_next  = cmd_addr;
                    end
                end
            end
            W_SAVE: begin
                state_next = W_COMMIT;
                d_in_next  = addr_reg;
            end
            W_COMMIT: state_next = IDLE;
            R_SHOW: begin
                state_next = R_WAIT;
                cnt_next   = CNT_LOAD;
            end
            R_WAIT: begin
                // Counter reaching zero marks the cycle in which lut_d_out is valid.
                if (cnt_reg == 4'd0) begin
                    rsp_data_next = lut_d_out;
                    state_next    = R_RSP;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            R_RSP: begin
                if (rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        // Outputs are decoded from the next state so they come straight out of flops.
        cmd_ready_next = (state_next == IDLE);
        busy_next      = (state_next != IDLE);
        save_next      = (state_next == W_SAVE);
        write_next     = (state_next == W_COMMIT);
        show_next      = (state_next == R_SHOW);
        rsp_valid_next = (state_next == R_RSP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            addr_reg      <= '0;
            cnt_reg       <= '0;
            d_in_reg      <= '0;
            rsp_data_reg  <= '0;
            cmd_ready_reg <= 1'b1;
            busy_reg      <= 1'b0;
            save_reg      <= 1'b0;
            write_reg     <= 1'b0;
            show_reg      <= 1'b0;
            rsp_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            addr_reg      <= addr_next;
            cnt_reg       <= cnt_next;
            d_in_reg      <= d_in_next;
            rsp_data_reg  <= rsp_data_next;
            cmd_ready_reg <= cmd_ready_next;
            busy_reg      <= busy_next;
            save_reg      <= save_next;
            write_reg     <= write_next;
            show_reg      <= show_next;
            rsp_valid_reg <= rsp_valid_next;
        end
    end

    assign cmd_ready     = cmd_ready_reg;
    assign busy          = busy_reg;
    assign lut_d_in      = d_in_reg;
    assign lut_save_data = save_reg;
    assign lut_write_en  = write_reg;
    assign lut_show_reg  = show_reg;
    assign rsp_valid     = rsp_valid_reg;
    assign rsp_data      = rsp_data_reg;

endmodule

// File: tb/tb_lut_ctrl.sv
// Directed bench for lut_ctrl: two instances (RD_LAT=1 and RD_LAT=3), each driving a small LUT model.
module tb_lut_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr_mem = 1'b0;
    int         vectors = 0;
    int         miscompares = 0;

    // Instance with RD_LAT=1
    logic       cmd_valid = 1'b0, cmd_wr = 1'b0, rsp_ready = 1'b0;
    logic [7:0] cmd_addr = 8'h00, cmd_data = 8'h00;
    logic       cmd_ready, rsp_valid, busy, save, wen, show;
    logic [7:0] rsp_data, d_in, d_out;

    // Instance with RD_LAT=3
    logic       cmd_valid3 = 1'b0, cmd_wr3 = 1'b0, rsp_ready3 = 1'b0;
    logic [7:0] cmd_addr3 = 8'h00, cmd_data3 = 8'h00;
    logic       cmd_ready3, rsp_valid3, busy3, save3, wen3, show3;
    logic [7:0] rsp_data3, d_in3, d_out3;

    always #5 clk = ~clk;

    lut_ctrl #(.DW(8), .RD_LAT(1)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .busy(busy), .lut_d_in(d_in), .lut_save_data(save),
        .lut_write_en(wen), .lut_show_reg(show), .lut_d_out(d_out)
    );

    lut_ctrl #(.DW(8), .RD_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3), .cmd_wr(cmd_wr3),
        .cmd_addr(cmd_addr3), .cmd_data(cmd_data3), .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
        .rsp_data(rsp_data3), .busy(busy3), .lut_d_in(d_in3), .lut_save_data(save3),
        .lut_write_en(wen3), .lut_show_reg(show3), .lut_d_out(d_out3)
    );

    // LUT models: save_data latches the operand, write_en commits it at d_in, show_reg
    // reads d_in; read data appears only in the single cycle RD_LAT after the strobe.
    logic [7:0] mem1 [256];
    logic [7:0] mem3 [256];
    logic [7:0] lat1, lat3, p1;
    logic [7:0] p3 [3];
    assign d_out  = p1;
    assign d_out3 = p3[2];

    always @(posedge clk) begin
        if (clr_mem) begin
            for (int i = 0; i < 256; i++) begin
                mem1[i] <= 8'h00;
                mem3[i] <= 8'h00;
            end
        end else begin
            if (wen)  mem1[d_in]  <= lat1;
            if (wen3) mem3[d_in3] <= lat3;
        end
        if (save)  lat1 <= d_in;
        if (save3) lat3 <= d_in3;
        p1    <= show ? mem1[d_in] : 8'h00;
        p3[0] <= show3 ? mem3[d_in3] : 8'h00;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        clr_mem = 1'b1;
        tick;
        tick;
        clr_mem = 1'b0;
        rst = 1'b0;
        vectors++;
        if ({cmd_ready, busy, save, wen, show, rsp_valid, d_in, rsp_data} !== {6'b100000, 8'h00, 8'h00}) begin
            miscompares++;
            $display("FAIL reset_vals: rdy/busy/sv/we/sh/rv=%b d_in=%h rsp=%h exp 100000 00 00",
                     {cmd_ready, busy, save, wen, show, rsp_valid}, d_in, rsp_data);
        end
        tick;
        vectors++;
        if ({cmd_ready, busy, cmd_ready3, busy3} !== 4'b1010) begin
            miscompares++;
            $display("FAIL reset_idle: got %b exp 1010", {cmd_ready, busy, cmd_ready3, busy3});
        end
    endtask

    task automatic test_write;
        logic [7:0] wa [2];
        logic [7:0] wd [2];
        wa[0] = 8'h01; wd[0] = 8'h15;
        wa[1] = 8'h02; wd[1] = 8'hA3;
        for (int i = 0; i < 2; i++) begin
            cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = wa[i]; cmd_data = wd[i];
            tick;
            cmd_valid = 1'b0; cmd_addr = 8'hFF; cmd_data = 8'hEE;
            vectors++;
            if ({save, wen, show, d_in, cmd_ready, busy} !== {3'b100, wd[i], 2'b01}) begin
                miscompares++;
                $display("FAIL wr_save[%0d]: sv/we/sh=%b d_in=%h rdy/busy=%b exp 100 %h 01",
                         i, {save, wen, show}, d_in, {cmd_ready, busy}, wd[i]);
            end
            tick;
            vectors++;
            if ({save, wen, show, d_in, cmd_ready, busy} !== {3'b010, wa[i], 2'b01}) begin
                miscompares++;
                $display("FAIL wr_commit[%0d]: sv/we/sh=%b d_in=%h rdy/busy=%b exp 010 %h 01",
                         i, {save, wen, show}, d_in, {cmd_ready, busy}, wa[i]);
            end
            tick;
            vectors++;
            if ({save, wen, show, d_in, cmd_ready, busy, mem1[wa[i]]} !== {3'b000, wa[i], 2'b10, wd[i]}) begin
                miscompares++;
                $display("FAIL wr_done[%0d]: sv/we/sh=%b d_in=%h rdy/busy=%b lut=%h exp 000 %h 10 %h",
                         i, {save, wen, show}, d_in, {cmd_ready, busy}, mem1[wa[i]], wa[i], wd[i]);
            end
        end
    endtask

    task automatic test_read;
        rsp_ready = 1'b0;
        cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 8'h02;
        tick;
        cmd_valid = 1'b0; cmd_addr = 8'hFF;
        vectors++;
        if ({save, wen, show, d_in, rsp_valid} !== {3'b001, 8'h02, 1'b0}) begin
            miscompares++;
            $display("FAIL rd_show: sv/we/sh=%b d_in=%h rv=%b exp 001 02 0", {save, wen, show}, d_in, rsp_valid);
        end
        tick;
        vectors++;
        if ({save, wen, show, d_in, rsp_valid, busy} !== {3'b000, 8'h02, 2'b01}) begin
            miscompares++;
            $display("FAIL rd_wait: sv/we/sh=%b d_in=%h rv/busy=%b exp 000 02 01", {save, wen, show}, d_in, {rsp_valid, busy});
        end
        for (int k = 0; k < 5; k++) begin
            tick;
            vectors++;
            if ({rsp_valid, rsp_data, cmd_ready} !== {1'b1, 8'hA3, 1'b0}) begin
                miscompares++;
                $display("FAIL rd_rsp_hold[%0d]: rv=%b rsp=%h rdy=%b exp 1 a3 0", k, rsp_valid, rsp_data, cmd_ready);
            end
        end
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        vectors++;
        if ({rsp_valid, rsp_data, cmd_ready, busy} !== {1'b0, 8'hA3, 2'b10}) begin
            miscompares++;
            $display("FAIL rd_release: rv=%b rsp=%h rdy/busy=%b exp 0 a3 10", rsp_valid, rsp_data, {cmd_ready, busy});
        end
    endtask

    task automatic test_early_ready_collision;
        rsp_ready = 1'b1;
        cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 8'h01;
        tick;
        cmd_valid = 1'b0;
        tick;
        vectors++;
        if ({rsp_valid, busy} !== 2'b01) begin
            miscompares++;
            $display("FAIL early_ready: rv/busy=%b exp 01", {rsp_valid, busy});
        end
        tick;
        vectors++;
        if ({rsp_valid, rsp_data} !== {1'b1, 8'h15}) begin
            miscompares++;
            $display("FAIL early_rsp: rv=%b rsp=%h exp 1 15", rsp_valid, rsp_data);
        end
        cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 8'h03; cmd_data = 8'h5A;
        tick;
        vectors++;
        if ({rsp_valid, cmd_ready, save} !== 3'b010) begin
            miscompares++;
            $display("FAIL collide_wait: rv/rdy/sv=%b exp 010", {rsp_valid, cmd_ready, save});
        end
        tick;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        vectors++;
        if ({save, d_in} !== {1'b1, 8'h5A}) begin
            miscompares++;
            $display("FAIL collide_accept: sv=%b d_in=%h exp 1 5a", save, d_in);
        end
        tick;
        tick;
    endtask

    task automatic test_back_to_back;
        logic       bw [3];
        logic [7:0] ba [3];
        logic [7:0] bd [3];
        int         acc_cyc [3];
        int         acc_n = 0;
        int         overlaps = 0;
        logic       acc;
        logic       seen = 1'b0;
        logic [7:0] got = 8'h00;
        bw[0] = 1'b1; ba[0] = 8'h01; bd[0] = 8'h15;
        bw[1] = 1'b1; ba[1] = 8'h02; bd[1] = 8'hA3;
        bw[2] = 1'b0; ba[2] = 8'h01; bd[2] = 8'h00;
        acc_cyc[0] = 0; acc_cyc[1] = 0; acc_cyc[2] = 0;
        clr_mem = 1'b1;
        tick;
        clr_mem = 1'b0;
        rsp_ready = 1'b1;
        cmd_valid = 1'b1; cmd_wr = bw[0]; cmd_addr = ba[0]; cmd_data = bd[0];
        for (int c = 0; c < 30; c++) begin
            acc = cmd_valid && cmd_ready;
            tick;
            if ($countones({save, wen, show}) > 1) overlaps++;
            if (rsp_valid) begin
                seen = 1'b1;
                got  = rsp_data;
            end
            if (acc) begin
                acc_cyc[acc_n] = c;
                acc_n++;
                if (acc_n < 3) begin
                    cmd_wr = bw[acc_n]; cmd_addr = ba[acc_n]; cmd_data = bd[acc_n];
                end else begin
                    cmd_valid = 1'b0;
                end
            end
        end
        rsp_ready = 1'b0;
        vectors++;
        if (acc_n !== 3) begin
            miscompares++;
            $display("FAIL b2b_accepts: got %0d exp 3", acc_n);
        end
        vectors++;
        if ({acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1]} !== {32'sd3, 32'sd3}) begin
            miscompares++;
            $display("FAIL b2b_spacing: gaps %0d %0d exp 3 3", acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1]);
        end
        vectors++;
        if ({seen, got, mem1[2]} !== {1'b1, 8'h15, 8'hA3}) begin
            miscompares++;
            $display("FAIL b2b_data: seen=%b rsp=%h lut[2]=%h exp 1 15 a3", seen, got, mem1[2]);
        end
        vectors++;
        if (overlaps !== 0) begin
            miscompares++;
            $display("FAIL b2b_overlap: got %0d overlapping cycles exp 0", overlaps);
        end
    endtask

    task automatic test_rd_lat3;
        cmd_valid3 = 1'b1; cmd_wr3 = 1'b1; cmd_addr3 = 8'h01; cmd_data3 = 8'h15;
        tick;
        cmd_valid3 = 1'b0;
        tick;
        tick;
        rsp_ready3 = 1'b0;
        cmd_valid3 = 1'b1; cmd_wr3 = 1'b0; cmd_addr3 = 8'h01;
        tick;
        cmd_valid3 = 1'b0; cmd_addr3 = 8'hFF;
        vectors++;
        if ({save3, wen3, show3, d_in3, busy3} !== {3'b001, 8'h01, 1'b1}) begin
            miscompares++;
            $display("FAIL lat3_show: sv/we/sh=%b d_in=%h busy=%b exp 001 01 1", {save3, wen3, show3}, d_in3, busy3);
        end
        for (int k = 2; k <= 4; k++) begin
            tick;
            vectors++;
            if ({save3, wen3, show3, d_in3, rsp_valid3} !== {3'b000, 8'h01, 1'b0}) begin
                miscompares++;
                $display("FAIL lat3_wait[N+%0d]: sv/we/sh=%b d_in=%h rv=%b exp 000 01 0",
                         k, {save3, wen3, show3}, d_in3, rsp_valid3);
            end
        end
        tick;
        vectors++;
        if ({rsp_valid3, rsp_data3} !== {1'b1, 8'h15}) begin
            miscompares++;
            $display("FAIL lat3_rsp: rv=%b rsp=%h exp 1 15", rsp_valid3, rsp_data3);
        end
        rsp_ready3 = 1'b1;
        tick;
        rsp_ready3 = 1'b0;
        vectors++;
        if ({rsp_valid3, cmd_ready3} !== 2'b01) begin
            miscompares++;
            $display("FAIL lat3_release: rv/rdy=%b exp 01", {rsp_valid3, cmd_ready3});
        end
    endtask

    task automatic test_reset_mid;
        int wen_seen = 0;
        cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 8'h02; cmd_data = 8'h87;
        tick;
        cmd_valid = 1'b0;
        vectors++;
        if ({save, d_in} !== {1'b1, 8'h87}) begin
            miscompares++;
            $display("FAIL rstmid_save: sv=%b d_in=%h exp 1 87", save, d_in);
        end
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if ({cmd_ready, busy, save, wen, show, rsp_valid, d_in, rsp_data} !== {6'b100000, 8'h00, 8'h00}) begin
            miscompares++;
            $display("FAIL rstmid_async: rdy/busy/sv/we/sh/rv=%b d_in=%h rsp=%h exp 100000 00 00",
                     {cmd_ready, busy, save, wen, show, rsp_valid}, d_in, rsp_data);
        end
        tick;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (wen) wen_seen++;
            tick;
        end
        vectors++;
        if ({wen_seen, mem1[2], cmd_ready, busy} !== {32'sd0, 8'hA3, 2'b10}) begin
            miscompares++;
            $display("FAIL rstmid_after: write_en pulses=%0d lut[2]=%h rdy/busy=%b exp 0 a3 10",
                     wen_seen, mem1[2], {cmd_ready, busy});
        end
    endtask

    initial begin
        test_reset;
        test_write;
        test_read;
        test_early_ready_collision;
        test_back_to_back;
        test_rd_lat3;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
